mac_seq: RTL and testbench

Dot-product sequencer wrapped around a signed multiply-accumulate datapath.
- Accepts a command giving a vector length N, then streams N signed operand pairs over a valid/ready interface.
- Accumulates the products and presents one result over a valid/ready interface.
- Sits between an operand source (buffer or DMA) and result consumer; replaces hand-sequenced reset/feed of the MAC.

---
 rtl/mac_seq_pkg.sv | 60 ++++++
 rtl/mac_seq_dp.sv | 50 +++++
 rtl/mac_seq.sv | 97 +++++++++
 tb/tb_mac_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: FSM state type and accumulate helpers for mac_seq.
// Define MAC_SEQ_SAT_EN to saturate the accumulator; default is wrap.
package mac_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int DEF_ACC_W = 16;
  localparam int ACC_MAX = (1 << (DEF_ACC_W - 1)) - 1;
  localparam int ACC_MIN = -(1 << (DEF_ACC_W - 1));

`ifdef MAC_SEQ_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  function automatic logic signed [32:0] lim_hi(
    input int w
  );
    return (33'sd1 <<< (w - 1)) - 33'sd1;
  endfunction

  // Operands arrive sign-extended to 32 bits; w is the real width.
  function automatic logic acc_ovf(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input int                 w
  );
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = {a[31], a} + {b[31], b};
    hi = lim_hi(w);
    lo = -hi - 33'sd1;
    return (s > hi) || (s < lo);
  endfunction

  function automatic logic signed [31:0] acc_add(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input int                 w,
    input bit                 sat
  );
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = {a[31], a} + {b[31], b};
    hi = lim_hi(w);
    lo = -hi - 33'sd1;
    if (sat && (s > hi)) return hi[31:0];
    if (sat && (s < lo)) return lo[31:0];
    return s[31:0];
  endfunction

endpackage

// File: rtl/mac_seq_dp.sv
// mac_seq_dp: two-stage signed MAC (product register, then accumulate).
// Saturation vs wrap comes from mac_seq_pkg (MAC_SEQ_SAT_EN).
module mac_seq_dp
  import mac_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc,
  output logic                     ovf
);

  logic signed [2*DATA_W-1:0] prod;
  logic                       prod_vld;
  logic signed [ACC_W-1:0]    acc_n;
  logic                       step_ovf;

  always_comb begin
    acc_n    = ACC_W'(acc_add(32'(acc), 32'(prod), ACC_W, SAT_EN));
    step_ovf = acc_ovf(32'(acc), 32'(prod), ACC_W);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
      ovf      <= 1'b0;
    end else begin
      prod_vld <= en;
      if (en)
        prod <= (2*DATA_W)'(a) * (2*DATA_W)'(b);
      // A new command always wins over a pending accumulate.
      if (clr) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (prod_vld) begin
        acc <= acc_n;
        ovf <= ovf | step_ovf;
      end
    end
  end

endmodule

// File: rtl/mac_seq.sv
// mac_seq: command-driven dot-product sequencer around mac_seq_dp.
// Build with MAC_SEQ_SAT_EN for a saturating accumulator.
module mac_seq
  import mac_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_ovf,
  output logic [LEN_W-1:0]  res_count,
  input  logic              abort,
  output logic              busy
);

  state_t             state;
  state_t             state_n;
  logic [LEN_W-1:0]   remaining;
  logic [LEN_W-1:0]   count;
  logic               cmd_acc;
  logic               in_acc;
  logic               last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (cmd_acc)
                 state_n = (cmd_len == '0) ? DONE : RUN;
        RUN:   if (in_acc && last)
                 state_n = DRAIN;
        DRAIN: state_n = DONE;
        DONE:  if (res_ready)
                 state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    in_ready  = (state == RUN);
    res_valid = (state == DONE);
    busy      = (state != IDLE);
    cmd_acc   = cmd_valid && cmd_ready && !abort;
    in_acc    = in_valid && in_ready && !abort;
    last      = (remaining == LEN_W'(1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining <= '0;
      count     <= '0;
    end else if (cmd_acc) begin
      remaining <= cmd_len;
      count     <= '0;
    end else if (in_acc) begin
      remaining <= remaining - LEN_W'(1);
      count     <= count + LEN_W'(1);
    end
  end

  mac_seq_dp #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_dp (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cmd_acc),
    .en      (in_acc),
    .a       (in_a),
    .b       (in_b),
    .acc     (res_data),
    .ovf     (res_ovf)
  );

  assign res_count = count;

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: directed + randomized checks of mac_seq against
// an arithmetic dot-product model.
module tb_mac_seq;

  localparam int HI = 32767;
  localparam int LO = -32768;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [10:0] cmd_len;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_ovf;
  logic [10:0] res_count;
  logic        abort;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int qa[$];
  int qb[$];

  always #5 clk = ~clk;

  mac_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ovf   (res_ovf),
    .res_count (res_count),
    .abort     (abort),
    .busy      (busy)
  );

  task automatic chk(
    input string              tag,
    input logic signed [31:0] obs,
    input logic signed [31:0] exp
  );
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Running signed sum; each step either wraps mod 2^16 or clamps.
  task automatic model(input int n, output int res, output int ovf);
    int acc;
    acc = 0;
    ovf = 0;
    for (int i = 0; i < n; i++) begin
      acc = acc + qa[i] * qb[i];
      if (acc > HI || acc < LO) begin
        ovf = 1;
`ifdef MAC_SEQ_SAT_EN
        acc = (acc > HI) ? HI : LO;
`else
        acc = (acc > HI) ? acc - 65536 : acc + 65536;
`endif
      end
    end
    res = acc;
  endtask

  task automatic fill(input int n, input int a, input int b);
    qa.delete();
    qb.delete();
    for (int i = 0; i < n; i++) begin
      qa.push_back(a);
      qb.push_back(b);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // gap: 0 = in_valid high, 1 = random, 2 = toggling.
  task automatic run_cmd(
    input string tag,
    input int    len,
    input int    gap,
    input int    wait_n,
    input bit    hold
  );
    int er;
    int eo;
    int i;
    int cyc;
    bit took;
    model(len, er, eo);
    cmd_valid = 1'b1;
    cmd_len   = 11'(len);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    if (len == 0) begin
      chk({tag, "_len0_valid"}, res_valid, 1);
      chk({tag, "_len0_in_ready"}, in_ready, 0);
    end else begin
      i   = 0;
      cyc = 0;
      while (i < len && cyc < 2000) begin
        if (gap == 0)      in_valid = 1'b1;
        else if (gap == 1) in_valid = 1'($urandom_range(0, 1));
        else               in_valid = (cyc % 2 == 0);
        in_a = 8'(qa[i]);
        in_b = 8'(qb[i]);
        took = in_valid && in_ready;
        @(negedge clk);
        cyc++;
        if (took) i++;
      end
      in_valid = 1'b0;
      chk({tag, "_accepts"}, i, len);
      chk({tag, "_drain_valid"}, res_valid, 0);
      chk({tag, "_drain_in_ready"}, in_ready, 0);
      @(negedge clk);
      chk({tag, "_res_valid"}, res_valid, 1);
    end
    res_ready = 1'b0;
    for (int k = 0; k < wait_n; k++) begin
      @(negedge clk);
      chk({tag, "_wait_cmd_ready"}, cmd_ready, 0);
      chk({tag, "_wait_data"}, $signed(res_data), er);
    end
    chk({tag, "_res_data"}, $signed(res_data), er);
    chk({tag, "_res_ovf"}, res_ovf, eo);
    chk({tag, "_res_count"}, res_count, len);
    chk({tag, "_busy_done"}, busy, 1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    cmd_valid = 1'b0;
    chk_idle({tag, "_after"});
  endtask

  initial begin
    logic [7:0] r;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    res_ready = 1'b0;
    abort     = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    chk("reset_data", $signed(res_data), 0);
    chk("reset_ovf", res_ovf, 0);
    chk("reset_count", res_count, 0);
    reset_n = 1'b1;
    @(negedge clk);

    qa = '{2, -4, 7};
    qb = '{3, 5, -1};
    run_cmd("basic", 3, 0, 0, 1'b0);

    run_cmd("len0", 0, 0, 1, 1'b0);

    fill(3, 127, 127);
    run_cmd("pos_ovf", 3, 0, 0, 1'b0);
    fill(3, -128, 127);
    run_cmd("neg_ovf", 3, 0, 0, 1'b0);

    fill(4, 1, 1);
    run_cmd("toggle", 4, 2, 5, 1'b1);

    // Abort after two accepts; the third offered pair loses to abort.
    fill(5, 2, 2);
    cmd_valid = 1'b1;
    cmd_len   = 11'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_a = 8'(qa[k]);
      in_b = 8'(qb[k]);
      chk("abort_in_ready", in_ready, 1);
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    chk_idle("abort");
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_res", res_valid, 0);
    end

    cmd_valid = 1'b1;
    cmd_len   = 11'd1;
    abort     = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    abort     = 1'b0;
    chk("abort_beats_cmd", busy, 0);

    fill(1, 3, 3);
    run_cmd("post_abort", 1, 0, 0, 1'b0);

    // Asynchronous reset in the middle of a clock phase.
    fill(5, 9, 9);
    cmd_valid = 1'b1;
    cmd_len   = 11'd5;
    @(negedge clk);
    cmd_valid = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_a = 8'(qa[k]);
      in_b = 8'(qb[k]);
      @(negedge clk);
    end
    #2 reset_n = 1'b0;
    #1;
    chk_idle("areset");
    chk("areset_data", $signed(res_data), 0);
    chk("areset_ovf", res_ovf, 0);
    chk("areset_count", res_count, 0);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    qa = '{2, -4, 7};
    qb = '{3, 5, -1};
    run_cmd("post_reset", 3, 0, 0, 1'b0);

    for (int t = 0; t < 10; t++) begin
      int n;
      n = $urandom_range(0, 12);
      qa.delete();
      qb.delete();
      for (int i = 0; i < n; i++) begin
        r = 8'($urandom);
        qa.push_back(int'($signed(r)));
        r = 8'($urandom);
        qb.push_back(int'($signed(r)));
      end
      run_cmd($sformatf("rand%0d", t), n, $urandom_range(0, 2),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
